// File: rtl/vote_arbiter_if.sv
// vote_arbiter_if: groups the raw ballot pins and the vote/display outputs of vote_arbiter.
//   master: drives mode/button1..4, observes the outputs (board pins / testbench side)
//   slave : the arbiter itself
//   mode         raw level, 1 = result-display phase
//   button1..4   raw candidate buttons (candidate index = button number - 1)
//   vote_valid   one-cycle vote command, vote_cand carries the candidate
//   multi_err    one-cycle pulse when a press is rejected for multiple buttons
//   disp_en      high during the result phase, disp_cand selects the shown candidate
//   busy         high while the controller is not idle
//   total_votes  accepted-vote count, saturating at 255
interface vote_arbiter_if;
    logic       mode;
    logic       button1;
    logic       button2;
    logic       button3;
    logic       button4;
    logic       vote_valid;
    logic [1:0] vote_cand;
    logic       multi_err;
    logic       disp_en;
    logic [1:0] disp_cand;
    logic       busy;
    logic [7:0] total_votes;

    modport master (
        output mode, button1, button2, button3, button4,
        input  vote_valid, vote_cand, multi_err, disp_en, disp_cand, busy, total_votes
    );

    modport slave (
        input  mode, button1, button2, button3, button4,
        output vote_valid, vote_cand, multi_err, disp_en, disp_cand, busy, total_votes
    );
endinterface

// File: rtl/vote_arbiter.sv
// vote_arbiter: qualifies raw ballot buttons, issues one vote command per valid press and
// sequences the result-display phase from the mode switch.
//   clk    sole clock, rising edge
//   reset  asynchronous active-low reset
//   bus    vote_arbiter_if slave: raw mode/button inputs, registered vote/display outputs
// All outputs are registered from the next state, so they change on the same edge the FSM
// enters the state that produces them.
module vote_arbiter #(
    parameter int unsigned HOLD_CYCLES    = 10,
    parameter int unsigned RELEASE_CYCLES = 4
) (
    input logic           clk,
    input logic           reset,
    vote_arbiter_if.slave bus
);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned RW = $clog2(RELEASE_CYCLES + 1);
    localparam logic [HW-1:0] HoldMax = HW'(HOLD_CYCLES);
    localparam logic [RW-1:0] RelLast = RW'(RELEASE_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StQualify, StCommit, StReject, StWaitRelease, StResult
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    btn_raw, btn_meta_q, s_btn;
    logic          mode_meta_q, s_mode;
    logic [1:0]    cand_q, cand_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          btn_onehot, btn_multi;
    logic [1:0]    btn_idx;
    logic [3:0]    cand_mask;

    logic       vote_valid_q, vote_valid_d;
    logic [1:0] vote_cand_q, vote_cand_d;
    logic       multi_err_q, multi_err_d;
    logic       disp_en_q, disp_en_d;
    logic [1:0] disp_cand_q, disp_cand_d;
    logic       busy_q, busy_d;
    logic [7:0] total_q, total_d;

    assign btn_raw = {bus.button4, bus.button3, bus.button2, bus.button1};

    // Two-flop synchronizers; the FSM only ever looks at s_btn / s_mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta_q  <= 4'd0;
            s_btn       <= 4'd0;
            mode_meta_q <= 1'b0;
            s_mode      <= 1'b0;
        end else begin
            btn_meta_q  <= btn_raw;
            s_btn       <= btn_meta_q;
            mode_meta_q <= bus.mode;
            s_mode      <= mode_meta_q;
        end
    end

    // x & (x-1) clears the lowest set bit, so zero means at most one bit was set.
    assign btn_onehot = (s_btn != 4'd0) && ((s_btn & (s_btn - 4'd1)) == 4'd0);
    assign btn_multi  = (s_btn != 4'd0) && !btn_onehot;
    assign cand_mask  = 4'b0001 << cand_q;

    always_comb begin
        btn_idx = 2'd0;
        case (s_btn)
            4'b0010: btn_idx = 2'd1;
            4'b0100: btn_idx = 2'd2;
            4'b1000: btn_idx = 2'd3;
            default: btn_idx = 2'd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        hcnt_d      = hcnt_q;
        rcnt_d      = rcnt_q;
        disp_cand_d = disp_cand_q;
        unique case (state_q)
            StIdle: begin
                if (s_mode) begin
                    state_d = StResult;
                end else if (btn_onehot) begin
                    state_d = StQualify;
                    cand_d  = btn_idx;
                    hcnt_d  = HW'(1);
                end else if (btn_multi) begin
                    state_d = StReject;
                end
            end
            StQualify: begin
                if (s_mode) begin
                    state_d = StResult;
                end else if (s_btn == 4'd0) begin
                    state_d = StIdle;
                end else if (s_btn != cand_mask) begin
                    state_d = StReject;
                end else if (hcnt_q == HoldMax) begin
                    state_d = StCommit;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
            // COMMIT and REJECT are single uninterruptible cycles.
            StCommit, StReject: begin
                state_d = StWaitRelease;
                rcnt_d  = '0;
            end
            StWaitRelease: begin
                if (s_mode) begin
                    state_d = StResult;
                end else if (s_btn != 4'd0) begin
                    rcnt_d = '0;
                end else if (rcnt_q == RelLast) begin
                    state_d = StIdle;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                end
            end
            StResult: begin
                if (btn_onehot) begin
                    disp_cand_d = btn_idx;
                end
                // Leaving via WAIT_RELEASE keeps a button held across the mode change from voting.
                if (!s_mode) begin
                    state_d = StWaitRelease;
                    rcnt_d  = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        vote_valid_d = (state_d == StCommit);
        multi_err_d  = (state_d == StReject);
        disp_en_d    = (state_d == StResult);
        busy_d       = (state_d != StIdle);
        vote_cand_d  = vote_cand_q;
        total_d      = total_q;
        if (state_d == StCommit) begin
            vote_cand_d = cand_q;
            if (total_q != 8'hff) begin
                total_d = total_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            cand_q       <= 2'd0;
            hcnt_q       <= '0;
            rcnt_q       <= '0;
            vote_valid_q <= 1'b0;
            vote_cand_q  <= 2'd0;
            multi_err_q  <= 1'b0;
            disp_en_q    <= 1'b0;
            disp_cand_q  <= 2'd0;
            busy_q       <= 1'b0;
            total_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            hcnt_q       <= hcnt_d;
            rcnt_q       <= rcnt_d;
            vote_valid_q <= vote_valid_d;
            vote_cand_q  <= vote_cand_d;
            multi_err_q  <= multi_err_d;
            disp_en_q    <= disp_en_d;
            disp_cand_q  <= disp_cand_d;
            busy_q       <= busy_d;
            total_q      <= total_d;
        end
    end

    assign bus.vote_valid  = vote_valid_q;
    assign bus.vote_cand   = vote_cand_q;
    assign bus.multi_err   = multi_err_q;
    assign bus.disp_en     = disp_en_q;
    assign bus.disp_cand   = disp_cand_q;
    assign bus.busy        = busy_q;
    assign bus.total_votes = total_q;
endmodule
